branch_pc_unit: RTL and testbench
=================================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL provide parameter DWIDTH, default 32, datapath and PC width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_2000, PC value loaded on reset.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL provide ports stall  input  1  hold PC and state; valid_in  input  1  current instruction valid.
REQ-006 SHALL provide ports is_branch, is_jal, is_jalr  input  1 each  instruction class flags.
REQ-007 SHALL provide ports funct3  input  3  branch condition; target  input  DWIDTH  ALU-computed redirect address.
REQ-008 SHALL provide ports br_eq, br_lt  input  1 each  results from the branch comparator.
REQ-009 SHALL provide port br_un  output  1  unsigned-compare select driven to the comparator.
REQ-010 SHALL provide ports pc  output  DWIDTH  current PC; taken  output  1  redirect decision this cycle.
REQ-011 SHALL provide ports flush  output  1  kill younger instruction; trap  output  1  misaligned-target trap active.
REQ-012 SHALL provide ports epc  output  DWIDTH  PC of trapping instruction; redirect_cnt  output  32  accepted-redirect count.

Function
REQ-013 br_un SHALL equal funct3[1], combinationally, regardless of other inputs.
REQ-014 Branch condition SHALL be: 000 br_eq; 001 !br_eq; 100 br_lt; 101 !br_lt; 110 br_lt; 111 !br_lt; 010/011 false.
REQ-015 taken SHALL be combinational: valid_in & state RUN & (is_jal | is_jalr | (is_branch & condition)).
REQ-016 Effective target SHALL be target for jal/branch, and target with bit 0 cleared for jalr.
REQ-017 Multiple class flags set simultaneously SHALL resolve by priority jal > jalr > branch.
REQ-018 The FSM SHALL have states RUN and TRAP; reset enters RUN.
REQ-019 In RUN with stall=1, pc, state, flush-next (0), and redirect_cnt SHALL hold; stall overrides any redirect.
REQ-020 In RUN with stall=0 and taken=0, pc SHALL become pc+4, modulo 2^DWIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 In RUN with stall=0, taken=1, and effective target[1:0]==0, pc SHALL become the effective target.
REQ-022 On acceptance per REQ-021, redirect_cnt SHALL increment by 1 (wrapping at 2^32) and flush SHALL be 1 in the next cycle only.
REQ-023 In RUN with stall=0, taken=1, and effective target[1:0]!=0, the block SHALL perform all of the following:
- move to TRAP;
- load epc with the current pc;
- leave pc and redirect_cnt unchanged;
- assert flush for the next cycle.
REQ-024 In TRAP, trap SHALL be 1, taken SHALL be 0, and pc, epc, and redirect_cnt SHALL hold; only rst exits TRAP.
REQ-025 flush SHALL be a registered output, 0 in every cycle not covered by REQ-022 or REQ-023.
REQ-026 With valid_in=0 and stall=0, pc SHALL advance by 4 (bubble fetch).

Reset
REQ-027 While rst=1 at a rising edge, the following values SHALL be loaded, overriding stall and all other inputs:
- pc=RESET_PC;
- state=RUN;
- flush=0;
- trap=0;
- epc=0;
- redirect_cnt=0.
REQ-028 rst asserted mid-operation, including in TRAP, SHALL take effect at the next edge with no residual flush.

Verification
REQ-029 Reset, then 3 cycles with valid_in=0 and stall=0 -> pc sequence 0x2000, 0x2004, 0x2008, 0x200C; flush=0; trap=0.
REQ-030 At pc=0x2008, BLT with funct3=100, br_lt=1, target=0x1000 -> taken=1 and br_un=0; next cycle pc=0x1000, flush=1, redirect_cnt=1; following cycle flush=0.
REQ-031 BGEU with funct3=111, br_lt=1 -> br_un=1, taken=0, pc+=4; repeat with stall=1 and is_jal=1 -> pc holds, redirect_cnt unchanged.
REQ-032 JALR at pc=0x1000 with target=0x3001 -> pc=0x3000, no trap; JAL at pc=0x3000 with target=0x4002 -> trap=1, epc=0x3000, pc holds 0x3000 for 5 cycles.
REQ-033 In TRAP, assert rst for one cycle -> pc=0x2000, trap=0, epc=0, redirect_cnt=0, flush=0.
REQ-034 Force pc to 0xFFFF_FFFC via jal target, then no branch -> pc=0x0000_0000 next cycle.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program-counter sequencer with branch/jump redirect,
// one-cycle flush on redirect, and a sticky misaligned-target trap.
module branch_pc_unit #(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              valid_in,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic [2:0]        funct3,
    input  logic [DWIDTH-1:0] target,
    input  logic              br_eq,
    input  logic              br_lt,
    output logic              br_un,
    output logic [DWIDTH-1:0] pc,
    output logic              taken,
    output logic              flush,
    output logic              trap,
    output logic [DWIDTH-1:0] epc,
    output logic [31:0]       redirect_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] w_pc_nxt;
    logic [DWIDTH-1:0] r_epc;
    logic [DWIDTH-1:0] w_epc_nxt;
    logic [31:0]       r_cnt;
    logic [31:0]       w_cnt_nxt;
    logic              r_flush;
    logic              w_flush_nxt;
    logic              w_cond;
    logic              w_taken;
    logic              w_misaligned;
    logic [DWIDTH-1:0] w_eff_target;

    // The comparator is told to compare unsigned for BLTU/BGEU (funct3[1]=1)
    assign br_un = funct3[1];

    // Branch condition decode from funct3 and comparator flags
    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = br_eq;
            3'b001:  w_cond = ~br_eq;
            3'b100:  w_cond = br_lt;
            3'b101:  w_cond = ~br_lt;
            3'b110:  w_cond = br_lt;
            3'b111:  w_cond = ~br_lt;
            default: w_cond = 1'b0;
        endcase
    end

    // Effective redirect address; jal wins over jalr, jalr clears bit 0
    always_comb begin
        w_eff_target = target;
        if (is_jal) begin
            w_eff_target = target;
        end else if (is_jalr) begin
            w_eff_target = {target[DWIDTH-1:1], 1'b0};
        end
    end

    assign w_taken      = valid_in & (r_state == ST_RUN) &
                          (is_jal | is_jalr | (is_branch & w_cond));
    assign w_misaligned = |w_eff_target[1:0];

    // Next-state logic: sequential fetch, redirect, or trap entry
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_cnt_nxt   = r_cnt;
        w_flush_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (w_taken) begin
                        w_flush_nxt = 1'b1;
                        if (w_misaligned) begin
                            // Trap keeps the faulting pc and records it in epc
                            w_state_nxt = ST_TRAP;
                            w_epc_nxt   = r_pc;
                        end else begin
                            w_pc_nxt  = w_eff_target;
                            w_cnt_nxt = r_cnt + 32'd1;
                        end
                    end else begin
                        w_pc_nxt = r_pc + DWIDTH'(4);
                    end
                end
            end
            ST_TRAP: begin
                // Frozen until reset
                w_state_nxt = ST_TRAP;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State register with synchronous reset overriding every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    assign pc           = r_pc;
    assign taken        = w_taken;
    assign flush        = r_flush;
    assign trap         = (r_state == ST_TRAP);
    assign epc          = r_epc;
    assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Testbench for branch_pc_unit: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the PC rules.
module tb_branch_pc_unit;

    localparam int          DW  = 32;
    localparam logic [31:0] RPC = 32'h0000_2000;

    logic          clk = 1'b0;
    logic          rst, stall, valid_in, is_branch, is_jal, is_jalr;
    logic [2:0]    funct3;
    logic [DW-1:0] target;
    logic          br_eq, br_lt;
    logic          br_un, taken, flush, trap;
    logic [DW-1:0] pc, epc;
    logic [31:0]   redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc, m_cnt;
    logic        m_trap, m_flush;
    bit          m_known = 0;

    branch_pc_unit #(.DWIDTH(DW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .valid_in(valid_in),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .target(target), .br_eq(br_eq), .br_lt(br_lt),
        .br_un(br_un), .pc(pc), .taken(taken), .flush(flush), .trap(trap),
        .epc(epc), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Branch outcome table for a conditional branch
    function automatic bit m_cond(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_taken();
        return valid_in && !m_trap &&
               (is_jal || is_jalr || (is_branch && m_cond(funct3, br_eq, br_lt)));
    endfunction

    function automatic logic [31:0] m_eff();
        if (!is_jal && is_jalr) return target - (target % 2);
        return target;
    endfunction

    task automatic set_in(input bit v, input bit b, input bit j, input bit jr,
                          input logic [2:0] f3, input logic [31:0] t,
                          input bit eq, input bit lt, input bit st);
        valid_in = v; is_branch = b; is_jal = j; is_jalr = jr;
        funct3 = f3; target = t; br_eq = eq; br_lt = lt; stall = st;
    endtask

    // One clock: check combinational outputs, clock, advance model, check state
    task automatic cycle();
        bit          tk;
        logic [31:0] ef;
        #1;
        tk = m_taken();
        ef = m_eff();
        if (m_known) begin
            chk("taken", {31'd0, taken}, {31'd0, tk});
            chk("br_un", {31'd0, br_un}, {31'd0, (funct3 == 3'd6 || funct3 == 3'd7 ||
                                                  funct3 == 3'd2 || funct3 == 3'd3)});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = RPC; m_epc = 0; m_cnt = 0; m_trap = 0; m_flush = 0; m_known = 1;
        end else if (m_known) begin
            m_flush = 0;
            if (!m_trap && !stall) begin
                if (tk) begin
                    m_flush = 1;
                    if (ef % 4 != 0) begin
                        m_trap = 1;
                        m_epc  = m_pc;
                    end else begin
                        m_pc  = ef;
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("flush", {31'd0, flush}, {31'd0, m_flush});
            chk("trap", {31'd0, trap}, {31'd0, m_trap});
            chk("epc", epc, m_epc);
            chk("redirect_cnt", redirect_cnt, m_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 3'd0, 32'd0, 0, 0, 1);
        cycle();
        chk("reset_pc", pc, 32'h2000);
        rst = 1'b0;

        // Bubble fetch sequence after reset
        set_in(0, 0, 0, 0, 3'd0, 32'd0, 0, 0, 0);
        cycle(); chk("bubble1", pc, 32'h2004);
        cycle(); chk("bubble2", pc, 32'h2008);
        cycle(); chk("bubble3", pc, 32'h200C);
        chk("bubble_flush", {31'd0, flush}, 32'd0);

        rst = 1'b1; cycle(); rst = 1'b0;

        // BGEU not taken with br_lt=1, unsigned compare selected
        set_in(1, 1, 0, 0, 3'b111, 32'h0000_1000, 0, 1, 0);
        #1; chk("bgeu_br_un", {31'd0, br_un}, 32'd1); chk("bgeu_taken", {31'd0, taken}, 32'd0);
        cycle(); chk("bgeu_pc", pc, 32'h2004);

        // Stall overrides a jal
        set_in(1, 0, 1, 0, 3'b111, 32'h0000_5000, 0, 1, 1);
        cycle(); chk("stall_pc", pc, 32'h2004); chk("stall_cnt", redirect_cnt, 32'd0);
        chk("stall_flush", {31'd0, flush}, 32'd0);

        set_in(0, 0, 0, 0, 3'd0, 32'd0, 0, 0, 0);
        cycle(); chk("pre_blt_pc", pc, 32'h2008);

        // BLT taken to 0x1000
        set_in(1, 1, 0, 0, 3'b100, 32'h0000_1000, 0, 1, 0);
        #1; chk("blt_taken", {31'd0, taken}, 32'd1); chk("blt_br_un", {31'd0, br_un}, 32'd0);
        cycle(); chk("blt_pc", pc, 32'h1000); chk("blt_flush", {31'd0, flush}, 32'd1);
        chk("blt_cnt", redirect_cnt, 32'd1);

        // JALR clears bit 0 of the target
        set_in(1, 0, 0, 1, 3'd0, 32'h0000_3001, 0, 0, 0);
        cycle(); chk("jalr_pc", pc, 32'h3000); chk("jalr_trap", {31'd0, trap}, 32'd0);
        chk("jalr_flush", {31'd0, flush}, 32'd1);

        // JAL to a misaligned target traps and freezes
        set_in(1, 0, 1, 0, 3'd0, 32'h0000_4002, 0, 0, 0);
        cycle(); chk("jal_trap", {31'd0, trap}, 32'd1); chk("jal_epc", epc, 32'h3000);
        chk("jal_trap_flush", {31'd0, flush}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 3'($urandom), $urandom, $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            cycle();
            chk("trap_hold_pc", pc, 32'h3000);
            chk("trap_hold_flush", {31'd0, flush}, 32'd0);
        end

        // Reset out of TRAP, with stall and a jal present
        rst = 1'b1;
        set_in(1, 0, 1, 0, 3'd0, 32'h0000_0010, 0, 0, 1);
        cycle();
        rst = 1'b0;
        chk("trap_rst_pc", pc, 32'h2000); chk("trap_rst_trap", {31'd0, trap}, 32'd0);
        chk("trap_rst_epc", epc, 32'd0); chk("trap_rst_cnt", redirect_cnt, 32'd0);
        chk("trap_rst_flush", {31'd0, flush}, 32'd0);

        // PC wrap at the top of the address space
        set_in(1, 0, 1, 0, 3'd0, 32'hFFFF_FFFC, 0, 0, 0);
        cycle(); chk("wrap_setup", pc, 32'hFFFF_FFFC);
        set_in(1, 1, 0, 0, 3'b000, 32'h0000_0100, 0, 0, 0);
        cycle(); chk("wrap_pc", pc, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) t = t | 32'd1;
            rst = (m_trap && $urandom_range(0, 3) == 0) || ($urandom_range(0, 60) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                   3'($urandom), t, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 4) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
